// File: rtl/mau_bcu_pkg.sv
// Shared definitions for the MAU-to-BCU arbiter: FSM state encoding, active-low
// strobe levels and the default BUSY timeout.
package mau_bcu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arbState_t;

    localparam logic ASSERT_N   = 1'b0;
    localparam logic DEASSERT_N = 1'b1;

    localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first active request found scanning upward
// from last+1 with wrap-around; returns it one-hot and as an index.
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pickIdx
);

    always_comb begin
        int   cand;
        logic found;
        pick    = '0;
        pickIdx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found         = 1'b1;
                pick[cand]    = 1'b1;
                pickIdx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bcu_arbiter.sv
// Round-robin sharing of one BCU between NUM_REQ MAU controllers; done strobes are
// routed back to the owner only. Define BCU_TIMEOUT_EN to abort stalled BUSY phases.
module bcu_arbiter
    import mau_bcu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
`ifdef BCU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_REQ-1:0] ReqRequest_n,
    input  logic [NUM_REQ-1:0] ReqWriteRequest_n,
    input  logic               ReadDoneFromBCU_n,
    input  logic               WriteDoneFromBCU_n,
    output logic               BCURequest_n,
    output logic               BCUWriteRequest_n,
    output logic [NUM_REQ-1:0] Grant,
    output logic [NUM_REQ-1:0] ReqReadDone_n,
    output logic [NUM_REQ-1:0] ReqWriteDone_n,
    output logic [NUM_REQ-1:0] ReqBusErr,
    output arbState_t          DbgState
);

    // Handshake: a MAU holds ReqRequest_n low until its Done_n pulse, then releases it;
    // the grant is only dropped after that release, and every grant is preceded by IDLE.
    arbState_t          state;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pickIdx;
    logic [IDX_W-1:0]   lastIdx;
    logic [IDX_W-1:0]   ownerIdx;
    logic               doneHit;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPicker (
        .req     (~ReqRequest_n),
        .last    (lastIdx),
        .pick    (pick),
        .pickIdx (pickIdx)
    );

    // The latched direction lives on BCUWriteRequest_n; the other strobe is ignored.
    assign doneHit = (BCUWriteRequest_n == ASSERT_N) ? (WriteDoneFromBCU_n == ASSERT_N)
                                                     : (ReadDoneFromBCU_n == ASSERT_N);
    assign DbgState = state;

`ifdef BCU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]   busyCnt;
    logic [NUM_REQ-1:0] busErr;
    logic               expired;

    // Counter holds BUSY cycles already elapsed, so expiry is one below the limit.
    assign expired   = (busyCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign ReqBusErr = busErr;
`else
    assign ReqBusErr = '0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state             <= ARB_IDLE;
            BCURequest_n      <= DEASSERT_N;
            BCUWriteRequest_n <= DEASSERT_N;
            Grant             <= '0;
            ReqReadDone_n     <= '1;
            ReqWriteDone_n    <= '1;
            lastIdx           <= IDX_W'(NUM_REQ - 1);
            ownerIdx          <= '0;
`ifdef BCU_TIMEOUT_EN
            busyCnt           <= '0;
            busErr            <= '0;
`endif
        end else begin
            ReqReadDone_n  <= '1;
            ReqWriteDone_n <= '1;
`ifdef BCU_TIMEOUT_EN
            busErr         <= '0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (|pick) begin
                        Grant             <= pick;
                        ownerIdx          <= pickIdx;
                        lastIdx           <= pickIdx;
                        BCURequest_n      <= ASSERT_N;
                        BCUWriteRequest_n <= ReqWriteRequest_n[pickIdx];
                        state             <= ARB_BUSY;
`ifdef BCU_TIMEOUT_EN
                        busyCnt           <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
`ifdef BCU_TIMEOUT_EN
                    busyCnt <= busyCnt + 1'b1;
                    if (!doneHit && expired) begin
                        busErr[ownerIdx] <= 1'b1;
                    end
                    if (doneHit || expired) begin
`else
                    if (doneHit) begin
`endif
                        if (BCUWriteRequest_n == ASSERT_N) begin
                            ReqWriteDone_n[ownerIdx] <= ASSERT_N;
                        end else begin
                            ReqReadDone_n[ownerIdx] <= ASSERT_N;
                        end
                        BCURequest_n      <= DEASSERT_N;
                        BCUWriteRequest_n <= DEASSERT_N;
                        state             <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    if (ReqRequest_n[ownerIdx] == DEASSERT_N) begin
                        Grant <= '0;
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcu_arbiter.sv
// Self-checking bench for bcu_arbiter: directed scenarios plus randomized rounds
// against a transaction-level model (rotating priority list, expected-grant queue).
module tb_bcu_arbiter;
    import mau_bcu_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 4;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [N-1:0] reqN = '1;
    logic [N-1:0] wrN = '1;
    logic         rdDoneN = 1'b1;
    logic         wrDoneN = 1'b1;
    logic         bcuReqN;
    logic         bcuWrN;
    logic [N-1:0] grant;
    logic [N-1:0] reqRdDoneN;
    logic [N-1:0] reqWrDoneN;
    logic [N-1:0] reqBusErr;
    arbState_t    dbgState;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];
    int           prio[$];

    bcu_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (1)
`ifdef BCU_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .ReqRequest_n       (reqN),
        .ReqWriteRequest_n  (wrN),
        .ReadDoneFromBCU_n  (rdDoneN),
        .WriteDoneFromBCU_n (wrDoneN),
        .BCURequest_n       (bcuReqN),
        .BCUWriteRequest_n  (bcuWrN),
        .Grant              (grant),
        .ReqReadDone_n      (reqRdDoneN),
        .ReqWriteDone_n     (reqWrDoneN),
        .ReqBusErr          (reqBusErr),
        .DbgState           (dbgState)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Priority list: front is the highest-priority requester; serving w rotates it to the back.
    function automatic void modelReset();
        prio.delete();
        for (int i = 0; i < N; i++) prio.push_back(i);
    endfunction

    function automatic int modelPick(input logic [N-1:0] set);
        foreach (prio[i]) if (set[prio[i]]) return prio[i];
        return -1;
    endfunction

    function automatic void modelServe(input int w);
        int h;
        do begin
            h = prio.pop_front();
            prio.push_back(h);
        end while (h != w);
    endfunction

    function automatic logic [N-1:0] oneHot(input int w);
        logic [N-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic doRound(input logic [N-1:0] set, input logic [N-1:0] dirs, input int delay,
                           input bit dropOwner, input bit wrongStrobe);
        int           win;
        int           endEdge;
        int           hold;
        bit           tmoFire;
        logic         expDir;
        logic [N-1:0] oh;
        logic [N-1:0] expRd;
        logic [N-1:0] expWr;
        logic [N-1:0] expErr;
        logic [N-1:0] expGrant;
        logic [N-1:0] allOnes;

        allOnes = '1;
        reqN = ~set;
        wrN  = dirs;
        win  = modelPick(set);
        modelServe(win);
        exp_q.push_back(oneHot(win));
        oh     = oneHot(win);
        expDir = dirs[win];
`ifdef BCU_TIMEOUT_EN
        tmoFire = (delay > TMO);
        endEdge = tmoFire ? TMO : delay;
`else
        tmoFire = 1'b0;
        endEdge = delay;
`endif
        tick();
        checkVal("grant", grant, exp_q.pop_front());
        checkVal("bcu_req_on", bcuReqN, 0);
        checkVal("bcu_dir", bcuWrN, expDir);
        checkVal("state_busy", dbgState, ARB_BUSY);

        for (int c = 1; c <= endEdge; c++) begin
            rdDoneN = 1'b1;
            wrDoneN = 1'b1;
            if (c == endEdge && !tmoFire) begin
                if (expDir == 1'b0) wrDoneN = 1'b0;
                else rdDoneN = 1'b0;
            end else if (wrongStrobe) begin
                if (expDir == 1'b0) rdDoneN = 1'b0;
                else wrDoneN = 1'b0;
            end
            if (dropOwner && c == 1) reqN[win] = 1'b1;
            for (int j = 0; j < N; j++) if (j != win) reqN[j] = 1'($urandom_range(0, 1));
            tick();
            if (c < endEdge) begin
                checkVal("busy_hold_req", bcuReqN, 0);
                checkVal("busy_hold_grant", grant, oh);
                checkVal("busy_no_rd", reqRdDoneN, allOnes);
                checkVal("busy_no_wr", reqWrDoneN, allOnes);
                checkVal("busy_no_err", reqBusErr, 0);
            end else begin
                expRd  = expDir ? ~oh : allOnes;
                expWr  = expDir ? allOnes : ~oh;
                expErr = tmoFire ? oh : '0;
                checkVal("rd_done", reqRdDoneN, expRd);
                checkVal("wr_done", reqWrDoneN, expWr);
                checkVal("bus_err", reqBusErr, expErr);
                checkVal("bcu_req_off", bcuReqN, 1);
                checkVal("bcu_dir_off", bcuWrN, 1);
                checkVal("grant_at_done", grant, oh);
            end
        end
        rdDoneN = 1'b1;
        wrDoneN = 1'b1;

        hold = dropOwner ? 0 : $urandom_range(0, 2);
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) reqN[win] = 1'b1;
            tick();
            if (h == 0) begin
                checkVal("rel_rd_clear", reqRdDoneN, allOnes);
                checkVal("rel_wr_clear", reqWrDoneN, allOnes);
                checkVal("rel_err_clear", reqBusErr, 0);
            end
            expGrant = (h == hold) ? '0 : oh;
            checkVal("rel_grant", grant, expGrant);
            checkVal("rel_state", dbgState, (h == hold) ? ARB_IDLE : ARB_RELEASE);
        end
    endtask

    initial begin
        logic [N-1:0] s;
        logic [N-1:0] d;
        int           w;
        int           maxDelay;

        modelReset();
        tick();
        tick();
        checkVal("rst_grant", grant, 0);
        checkVal("rst_bcu_req", bcuReqN, 1);
        checkVal("rst_bcu_dir", bcuWrN, 1);
        checkVal("rst_rd_done", reqRdDoneN, 2'b11);
        checkVal("rst_wr_done", reqWrDoneN, 2'b11);
        checkVal("rst_bus_err", reqBusErr, 0);
        checkVal("rst_state", dbgState, ARB_IDLE);
        Rst = 1'b0;
        tick();
        checkVal("idle_no_req", grant, 0);

        // req0 read, BCU answers 3 cycles later
        doRound(2'b01, 2'b11, 3, 1'b0, 1'b0);
        // both requesting continuously: grants alternate
        for (int i = 0; i < 4; i++) doRound(2'b11, 2'($urandom), 2, 1'b0, 1'b0);
        // req1 write with a stray read strobe beforehand
        doRound(2'b10, 2'b01, 3, 1'b0, 1'b1);
        // owner drops its request while BUSY
        doRound(2'b01, 2'b11, 4, 1'b1, 1'b0);
`ifdef BCU_TIMEOUT_EN
        doRound(2'b01, 2'b11, TMO + 3, 1'b0, 1'b0);
        doRound(2'b10, 2'b00, TMO, 1'b0, 1'b1);
        maxDelay = TMO + 2;
`else
        maxDelay = 6;
`endif

        // reset in the middle of a BUSY phase owned by req1
        modelReset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        doRound(2'b11, 2'b11, 1, 1'b0, 1'b0);
        reqN = 2'b00;
        wrN  = 2'b00;
        w = modelPick(2'b11);
        modelServe(w);
        exp_q.push_back(oneHot(w));
        tick();
        checkVal("pre_rst_grant", grant, exp_q.pop_front());
        tick();
        #2 Rst = 1'b1;
        #1;
        checkVal("async_rst_req", bcuReqN, 1);
        checkVal("async_rst_grant", grant, 0);
        checkVal("async_rst_state", dbgState, ARB_IDLE);
        modelReset();
        tick();
        Rst = 1'b0;
        reqN = '1;
        doRound(2'b11, 2'b10, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s = N'($urandom_range(1, (1 << N) - 1));
            d = N'($urandom);
            doRound(s, d, $urandom_range(1, maxDelay), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
